add_pipe_core: RTL and testbench
================================

# add_pipe_core

Handshaked, buffered unsigned adder that sits between the add_input and add_output interfaces of the add_ben bench. It accepts operand pairs on a valid/ready input channel and presents carry-extended sums on a valid/ready output channel through a 2-entry result buffer. It also keeps a running count of delivered results. The add_input BFM drives this block's input channel, and the add_output BFM monitors and back-pressures its output channel.

## Interface
- DATA_WIDTH, 8, operand width in bits; must be at least 1.
- CNT_WIDTH, 16, width of the delivered-result counter.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_a  input  DATA_WIDTH  operand A, unsigned.
- in_b  input  DATA_WIDTH  operand B, unsigned.
- out_valid  output  1  out_sum holds a result.
- out_ready  input  1  consumer takes out_sum this cycle.
- out_sum  output  DATA_WIDTH+1  in_a+in_b; the MSB is the carry.
- done_count  output  CNT_WIDTH  number of results delivered since reset.

## Operation
- Result buffer: 2-entry FIFO of DATA_WIDTH+1 bits, with a read pointer, a write pointer and a 2-bit occupancy `occ` (0..2).
- in_ready = (occ != 2).
  - Registered function of occupancy only; there is no combinational path from out_ready.
- Push: when in_valid && in_ready at an edge, the full-width sum {1'b0,in_a}+{1'b0,in_b} is written at the write pointer, and the write pointer toggles.
- Pop: when out_valid && out_ready at an edge, the read pointer toggles and done_count increments.
- out_valid = (occ != 0).
- out_sum = entry at the read pointer; it holds stable while out_valid && !out_ready.
- Occupancy update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Push and pop together are legal only when occ is 1; at occ 2 there is no push, and at occ 0 there is no pop.
- done_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Inputs are ignored when in_ready=0. in_a/in_b need not hold stable after acceptance.
- Ordering is strictly FIFO: results leave in acceptance order, with no drops and no duplicates.
- Arithmetic is unsigned with no saturation. The maximum value is 2*(2^DATA_WIDTH-1), which fits in DATA_WIDTH+1 bits.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_sum=0
  - done_count=0
  - occ=0
  - both pointers 0
  - all buffer entries 0
- Reset asserted mid-operation discards all buffered results immediately (asynchronously). Outputs take their reset values while reset is high.
- The first accept is possible on the first rising edge after reset deasserts.
- Latency: an operand pair accepted at edge N appears with out_valid=1 after edge N, so it is available for a pop at edge N+1. Minimum latency is 1 cycle.
- Throughput: one result per cycle when out_ready is held high.
- Fill from empty with out_ready=0: two accepts, then in_ready=0 after the second accept edge.
- From full: in_ready returns to 1 on the edge that performs the pop (seen the cycle after).
- Valid rule: once asserted, out_valid stays high until the pop. The block never retracts a presented result.

## Test plan
- Reset/basic:
  - Stimulus: check all outputs during and after reset; then accept in_a=8'h12, in_b=8'h34 with out_ready=1.
  - Required response: reset values as listed above; out_sum=9'h046 one cycle after accept; done_count=1 after the pop.
- Carry:
  - Stimulus: in_a=8'hFF, in_b=8'h01, then in_a=8'hFF, in_b=8'hFF.
  - Required response: out_sum=9'h100, then 9'h1FE, in order.
- Backpressure full:
  - Stimulus: out_ready=0 while sending 3 pairs (1+1, 2+2, 3+3) back to back; then raise out_ready.
  - Required response: in_ready drops after the second accept and the third pair waits; outputs arrive as 2, 4, 6, in order.
- Streaming:
  - Stimulus: 100 random pairs, with in_valid and out_ready each toggled randomly at 50%.
  - Required response: every sum matches the scoreboard, in order; done_count=100.
- Reset mid-operation:
  - Stimulus: with occ=2, assert reset between edges.
  - Required response: out_valid=0, in_ready=1 and done_count=0 immediately; previously held results never appear after reset.
- Counter wrap (CNT_WIDTH=4):
  - Stimulus: deliver 17 results.
  - Required response: done_count reads 15 after 15 pops, 0 after 16, and 1 after 17.

Source files
------------

// File: rtl/add_pipe_core.sv
// add_pipe_core
//   Handshaked unsigned adder with a 2-entry result FIFO and a running count
//   of delivered results.
//
// Parameters
//   DATA_WIDTH  operand width (>= 1)
//   CNT_WIDTH   width of the delivered-result counter
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high; clears all state
//   in_valid    operand pair on in_a/in_b is valid
//   in_ready    block can accept a pair (buffer not full)
//   in_a, in_b  unsigned operands
//   out_valid   out_sum holds a result (buffer not empty)
//   out_ready   consumer takes out_sum this cycle
//   out_sum     carry-extended sum at the head of the buffer
//   done_count  results delivered since reset, wraps silently
module add_pipe_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_sum,
    output logic [CNT_WIDTH-1:0]  done_count
);

    logic [DATA_WIDTH:0]  mem_q [2];
    logic [DATA_WIDTH:0]  mem_d [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           occ_q, occ_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 push, pop;

    // Handshake outputs depend only on registered occupancy, so there is
    // no combinational path from out_ready to in_ready.
    assign in_ready   = (occ_q != 2'd2);
    assign out_valid  = (occ_q != 2'd0);
    assign out_sum    = mem_q[rd_ptr_q];
    assign done_count = cnt_q;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;

        push = in_valid && in_ready;
        pop  = out_valid && out_ready;

        if (push) begin
            mem_d[wr_ptr_q] = {1'b0, in_a} + {1'b0, in_b};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_add_pipe_core.sv
// Testbench for add_pipe_core: a queue-based reference model checked every
// cycle, plus directed literal expectations. A second instance with
// CNT_WIDTH=4 exercises counter wrap.
module tb_add_pipe_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_sum;
    logic [15:0] done_count;

    logic        w_in_valid = 1'b0;
    logic        w_in_ready;
    logic [7:0]  w_in_a = '0;
    logic [7:0]  w_in_b = '0;
    logic        w_out_valid;
    logic        w_out_ready = 1'b0;
    logic [8:0]  w_out_sum;
    logic [3:0]  w_done_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    add_pipe_core #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .done_count(done_count)
    );

    add_pipe_core #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .clock(clock), .reset(reset),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
        .done_count(w_done_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of the result buffer as a queue.
    logic [8:0]  model_q[$];
    logic [15:0] model_cnt = '0;
    int          model_pushes = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_q.delete();
            model_cnt = '0;
        end else begin
            bit do_push, do_pop;
            do_push = in_valid && (model_q.size() < 2);
            do_pop  = out_ready && (model_q.size() > 0);
            if (do_pop) begin
                void'(model_q.pop_front());
                model_cnt = model_cnt + 16'd1;
            end
            if (do_push) begin
                model_q.push_back(9'(in_a) + 9'(in_b));
                model_pushes++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            chk("model_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
            chk("model_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            chk("model_done_count", 32'(done_count), 32'(model_cnt));
            if (model_q.size() > 0)
                chk("model_out_sum", 32'(out_sum), 32'(model_q[0]));
        end
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    initial begin
        int base;
        int n;

        // Reset values while reset is held.
        cyc(); cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_done_count", 32'(done_count), 32'd0);
        reset = 1'b0;
        cyc();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Basic accept, one-cycle latency, count after pop.
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_sum", 32'(out_sum), 32'h046);
        cyc();
        chk("basic_count", 32'(done_count), 32'd1);
        chk("basic_empty", 32'(out_valid), 32'd0);

        // Carry out.
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'h01;
        cyc();
        chk("carry_sum0", 32'(out_sum), 32'h100);
        in_a = 8'hFF; in_b = 8'hFF;
        cyc();
        in_valid = 1'b0;
        chk("carry_sum1", 32'(out_sum), 32'h1FE);
        cyc();

        // Backpressure: fill, third pair waits, drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
        cyc();
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        in_a = 8'd2; in_b = 8'd2;
        cyc();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        in_a = 8'd3; in_b = 8'd3;
        cyc();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_head_held", 32'(out_sum), 32'd2);
        out_ready = 1'b1;
        cyc();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_sum4", 32'(out_sum), 32'd4);
        cyc();
        in_valid = 1'b0;
        chk("bp_sum6", 32'(out_sum), 32'd6);
        cyc();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Reset mid-operation with buffer full.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'd10; in_b = 8'd20;
        cyc();
        in_a = 8'd30; in_b = 8'd40;
        cyc();
        in_valid = 1'b0;
        chk("mid_full", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_count", 32'(done_count), 32'd0);
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        cyc(); cyc();
        chk("mid_no_stale", 32'(out_valid), 32'd0);

        // Streaming with random valid/ready.
        base = model_pushes;
        n = 0;
        while ((model_pushes - base) < 100 && n < 5000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            n++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (model_q.size() > 0 && n < 10) begin
            cyc();
            n++;
        end
        chk("stream_accepted", 32'(model_pushes - base), 32'd100);
        chk("stream_drained", 32'(model_q.size()), 32'd0);
        cyc();
        chk("stream_count", 32'(done_count), 32'd100);

        // Counter wrap on the 4-bit instance: one push per cycle, pops
        // trail by one edge.
        w_out_ready = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            w_in_valid = (i <= 17);
            w_in_a = 8'(i);
            w_in_b = 8'd0;
            cyc();
            if (i == 16) chk("wrap_15", 32'(w_done_count), 32'd15);
            if (i == 17) chk("wrap_0", 32'(w_done_count), 32'd0);
            if (i == 18) chk("wrap_1", 32'(w_done_count), 32'd1);
        end
        w_in_valid = 1'b0;
        cyc();
        chk("wrap_empty", 32'(w_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
